addr_trans: RTL and testbench

Combinational virtual-to-physical address translator for the LoongArch32 core, used by the memory-1 stage for loads and stores and reusable by fetch. From the CSR view and the TLB entry array it selects the translation source: direct mode, DMW0/DMW1 window, or TLB lookup. It produces the physical address, the memory access type, and any alignment or translation exception.

---
 rtl/addr_trans_pkg.sv | 86 ++++++++
 rtl/addr_trans_tlb_lookup.sv | 45 ++++
 rtl/addr_trans.sv | 80 ++++++++
 tb/tb_addr_trans.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/addr_trans_pkg.sv
// Shared types and constants for the LoongArch32 address translation path.
package addr_trans_pkg;

    localparam int TLB_ENTRY_NUM = 16;

    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PME  = 6'h04;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    typedef logic [1:0]  mat_t;
    typedef logic [31:0] phy_t;

    typedef enum logic [1:0] {LOOKUP_FETCH = 2'd0, LOOKUP_LOAD = 2'd1, LOOKUP_STORE = 2'd2} lookup_t;
    typedef enum logic [1:0] {BYTE = 2'd0, HALF_WORD = 2'd1, WORD = 2'd2} byte_type_t;

    typedef struct packed {
        logic [1:0] plv;
        logic       da;
        logic       pg;
        mat_t       datf;
        mat_t       datm;
    } crmd_t;

    typedef struct packed {
        logic       plv0;
        logic       plv3;
        mat_t       mat;
        logic [2:0] pseg;
        logic [2:0] vseg;
    } dmw_t;

    typedef struct packed {
        logic [9:0] asid;
    } asid_t;

    typedef struct packed {
        crmd_t crmd;
        dmw_t  dmw0;
        dmw_t  dmw1;
        asid_t asid;
    } csr_t;

    typedef struct packed {
        logic        e;
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic        g;
        logic [9:0]  asid;
        logic [19:0] ppn0;
        logic [19:0] ppn1;
        logic [1:0]  plv0;
        logic [1:0]  plv1;
        mat_t        mat0;
        mat_t        mat1;
        logic        d0;
        logic        d1;
        logic        v0;
        logic        v1;
    } tlb_entry_t;

    typedef struct packed {
        logic        hit;
        logic [5:0]  ps;
        logic [19:0] ppn;
        logic [1:0]  plv;
        mat_t        mat;
        logic        d;
        logic        v;
    } tlb_res_t;

    typedef struct packed {
        logic        valid;
        logic [14:0] esubcode_ecode;
        logic [31:0] badv;
    } excp_pass_t;

    function automatic logic dmw_hit(input logic [1:0] plv, input dmw_t dmw, input logic [2:0] vseg);
        return ((plv == 2'd0 && dmw.plv0) || (plv == 2'd3 && dmw.plv3)) && (vseg == dmw.vseg);
    endfunction

endpackage

// File: rtl/addr_trans_tlb_lookup.sv
// Parallel TLB compare, lowest-index priority pick and even/odd page select.
module tlb_lookup
    import addr_trans_pkg::*;
#(
    parameter int ENTRIES = TLB_ENTRY_NUM
) (
    input  logic [31:12] vpn,
    input  logic [9:0]   asid,
    input  tlb_entry_t   entrys [ENTRIES],
    output tlb_res_t     res
);

    logic [ENTRIES-1:0] match;
    tlb_entry_t         sel;
    logic               odd;

    always_comb begin
        match = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            match[i] = entrys[i].e && (entrys[i].g || entrys[i].asid == asid) &&
                       ((entrys[i].ps == 6'd21) ? (vpn[31:22] == entrys[i].vppn[18:9])
                                                : (vpn[31:13] == entrys[i].vppn));
        end
    end

    // Walk from the top so the lowest matching index is the last one written.
    always_comb begin
        sel = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (match[i]) sel = entrys[i];
        end
    end

    always_comb begin
        odd     = (sel.ps == 6'd21) ? vpn[21] : vpn[12];
        res.hit = |match;
        res.ps  = sel.ps;
        res.ppn = odd ? sel.ppn1 : sel.ppn0;
        res.plv = odd ? sel.plv1 : sel.plv0;
        res.mat = odd ? sel.mat1 : sel.mat0;
        res.d   = odd ? sel.d1   : sel.d0;
        res.v   = odd ? sel.v1   : sel.v0;
    end

endmodule

// File: rtl/addr_trans.sv
// Combinational VA->PA translation: direct mode, DMW windows or TLB, plus exception priority.
module addr_trans
    import addr_trans_pkg::*;
#(
    parameter int TLB_ENTRY_NUM = addr_trans_pkg::TLB_ENTRY_NUM
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] va,
    input  lookup_t     lookup_type,
    input  byte_type_t  byte_type,
    input  csr_t        rd_csr,
    input  tlb_entry_t  tlb_entrys [TLB_ENTRY_NUM],
    output mat_t        mat,
    output phy_t        pa,
    output excp_pass_t  excp
);

    // Purely combinational; clock and reset exist only for port compatibility.
    logic unused_ok;
    assign unused_ok = clk ^ rst_n;

    tlb_res_t tres;
    logic     direct, dmw0_hit, dmw1_hit, tlb_path;
    logic     fetch, store, misaligned, fault;
    logic [5:0] ecode;

    tlb_lookup #(.ENTRIES(TLB_ENTRY_NUM)) u_tlb (
        .vpn    (va[31:12]),
        .asid   (rd_csr.asid.asid),
        .entrys (tlb_entrys),
        .res    (tres)
    );

    assign direct   = rd_csr.crmd.da && !rd_csr.crmd.pg;
    assign dmw0_hit = !direct && dmw_hit(rd_csr.crmd.plv, rd_csr.dmw0, va[31:29]);
    assign dmw1_hit = !direct && !dmw0_hit && dmw_hit(rd_csr.crmd.plv, rd_csr.dmw1, va[31:29]);
    assign tlb_path = !direct && !dmw0_hit && !dmw1_hit;

    always_comb begin
        pa  = va;
        mat = '0;
        if (direct) begin
            mat = (lookup_type == LOOKUP_FETCH) ? rd_csr.crmd.datf : rd_csr.crmd.datm;
        end else if (dmw0_hit) begin
            pa  = {rd_csr.dmw0.pseg, va[28:0]};
            mat = rd_csr.dmw0.mat;
        end else if (dmw1_hit) begin
            pa  = {rd_csr.dmw1.pseg, va[28:0]};
            mat = rd_csr.dmw1.mat;
        end else if (tres.hit) begin
            pa  = (tres.ps == 6'd21) ? {tres.ppn[19:9], va[20:0]} : {tres.ppn, va[11:0]};
            mat = tres.mat;
        end
    end

    assign fetch      = (lookup_type == LOOKUP_FETCH);
    assign store      = (lookup_type == LOOKUP_STORE);
    assign misaligned = (byte_type == HALF_WORD && va[0]) || (byte_type == WORD && va[1:0] != 2'b00);

    always_comb begin
        fault = 1'b1;
        ecode = '0;
        if (fetch && va[1:0] != 2'b00)                    ecode = ECODE_ADEF;
        else if (!fetch && misaligned)                    ecode = ECODE_ALE;
        else if (tlb_path && !tres.hit)                   ecode = ECODE_TLBR;
        else if (tlb_path && !tres.v)                     ecode = fetch ? ECODE_PIF : (store ? ECODE_PIS : ECODE_PIL);
        else if (tlb_path && rd_csr.crmd.plv > tres.plv)  ecode = ECODE_PPI;
        else if (tlb_path && store && !tres.d)            ecode = ECODE_PME;
        else                                              fault = 1'b0;
    end

    always_comb begin
        excp.valid          = en && fault;
        excp.esubcode_ecode = excp.valid ? {9'd0, ecode} : 15'd0;
        excp.badv           = excp.valid ? va : 32'd0;
    end

endmodule

// File: tb/tb_addr_trans.sv
// Scoreboard bench for addr_trans: expectations queued at drive time, checked half a cycle later.
module tb_addr_trans;
    import addr_trans_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en;
    logic [31:0] va;
    lookup_t     lookup_type;
    byte_type_t  byte_type;
    csr_t        rd_csr;
    tlb_entry_t  tlb_entrys [TLB_ENTRY_NUM];
    mat_t        mat;
    phy_t        pa;
    excp_pass_t  excp;

    addr_trans dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .va          (va),
        .lookup_type (lookup_type),
        .byte_type   (byte_type),
        .rd_csr      (rd_csr),
        .tlb_entrys  (tlb_entrys),
        .mat         (mat),
        .pa          (pa),
        .excp        (excp)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] pa;
        logic [1:0]  mat;
        logic        vld;
        logic [14:0] code;
        logic [31:0] badv;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Drive one access, queue what it should produce, then score it on the falling edge.
    task automatic drive(input string tag, input lookup_t lt, input byte_type_t bt, input logic [31:0] a,
                         input logic [31:0] epa, input logic [1:0] emat, input logic evld, input logic [5:0] ecode);
        exp_t e;
        exp_t got;
        lookup_type = lt;
        byte_type   = bt;
        va          = a;
        e.tag  = tag;
        e.pa   = epa;
        e.mat  = emat;
        e.vld  = evld;
        e.code = evld ? {9'd0, ecode} : 15'd0;
        e.badv = evld ? a : 32'd0;
        sb_q.push_back(e);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            chk({tag, ".queue"}, 64'd0, 64'd1);
        end else begin
            got = sb_q.pop_front();
            chk({got.tag, ".pa"},   {32'd0, pa},                    {32'd0, got.pa});
            chk({got.tag, ".mat"},  {62'd0, mat},                   {62'd0, got.mat});
            chk({got.tag, ".vld"},  {63'd0, excp.valid},            {63'd0, got.vld});
            chk({got.tag, ".code"}, {49'd0, excp.esubcode_ecode},   {49'd0, got.code});
            chk({got.tag, ".badv"}, {32'd0, excp.badv},             {32'd0, got.badv});
        end
        @(posedge clk);
    endtask

    initial begin
        en          = 1'b1;
        va          = '0;
        lookup_type = LOOKUP_LOAD;
        byte_type   = WORD;
        rd_csr      = '0;
        for (int i = 0; i < TLB_ENTRY_NUM; i++) tlb_entrys[i] = '0;
        @(posedge clk);

        // Direct mode, checked while reset is still held
        rd_csr.crmd.da   = 1'b1;
        rd_csr.crmd.pg   = 1'b0;
        rd_csr.crmd.datm = 2'd1;
        rd_csr.crmd.datf = 2'd2;
        drive("rst_direct", LOOKUP_LOAD, WORD, 32'h1C00_0100, 32'h1C00_0100, 2'd1, 1'b0, 6'h00);
        rst_n = 1'b1;
        drive("direct_ld",    LOOKUP_LOAD,  WORD,      32'h1C00_0100, 32'h1C00_0100, 2'd1, 1'b0, 6'h00);
        drive("direct_if",    LOOKUP_FETCH, WORD,      32'h1C00_0100, 32'h1C00_0100, 2'd2, 1'b0, 6'h00);
        drive("direct_adef",  LOOKUP_FETCH, WORD,      32'h1C00_0102, 32'h1C00_0102, 2'd2, 1'b1, ECODE_ADEF);
        drive("direct_ale_h", LOOKUP_LOAD,  HALF_WORD, 32'h1C00_0101, 32'h1C00_0101, 2'd1, 1'b1, ECODE_ALE);

        // DMW windows, both aimed at the same segment
        rd_csr.crmd = '{plv: 2'd0, da: 1'b0, pg: 1'b1, datf: 2'd0, datm: 2'd0};
        rd_csr.dmw0 = '{plv0: 1'b1, plv3: 1'b0, mat: 2'd0, pseg: 3'b000, vseg: 3'b101};
        rd_csr.dmw1 = '{plv0: 1'b1, plv3: 1'b1, mat: 2'd1, pseg: 3'b111, vseg: 3'b101};
        drive("dmw0_hit", LOOKUP_LOAD, WORD, 32'hA000_1234, 32'h0000_1234, 2'd0, 1'b0, 6'h00);
        rd_csr.crmd.plv = 2'd3;
        drive("dmw1_plv3", LOOKUP_LOAD, WORD, 32'hA000_1234, 32'hE000_1234, 2'd1, 1'b0, 6'h00);
        rd_csr.crmd.plv = 2'd0;
        rd_csr.dmw0 = '0;
        rd_csr.dmw1 = '0;

        // TLB 4 KiB: entry 3 live, entry 1 disabled, entry 2 foreign ASID, entry 7 shadowed duplicate
        tlb_entrys[3] = '{e: 1'b1, vppn: 19'h00010, ps: 6'd12, g: 1'b1, asid: 10'd0,
                          ppn0: 20'h0ABCD, ppn1: 20'h12345, plv0: 2'd0, plv1: 2'd3,
                          mat0: 2'd0, mat1: 2'd1, d0: 1'b1, d1: 1'b1, v0: 1'b1, v1: 1'b1};
        tlb_entrys[1] = tlb_entrys[3];
        tlb_entrys[1].e = 1'b0;
        tlb_entrys[1].ppn1 = 20'h11111;
        tlb_entrys[2] = tlb_entrys[3];
        tlb_entrys[2].g = 1'b0;
        tlb_entrys[2].asid = 10'd5;
        tlb_entrys[2].ppn1 = 20'h22222;
        tlb_entrys[7] = tlb_entrys[3];
        tlb_entrys[7].ppn1 = 20'h55555;
        drive("tlb4k_st",   LOOKUP_STORE, WORD, 32'h0002_1ABC, 32'h1234_5ABC, 2'd1, 1'b0, 6'h00);
        drive("tlb4k_even", LOOKUP_LOAD,  WORD, 32'h0002_0AB0, 32'h0ABC_DAB0, 2'd0, 1'b0, 6'h00);
        rd_csr.crmd.plv = 2'd3;
        drive("tlb_ppi",    LOOKUP_LOAD,  WORD, 32'h0002_0AB0, 32'h0ABC_DAB0, 2'd0, 1'b1, ECODE_PPI);
        rd_csr.crmd.plv = 2'd0;
        tlb_entrys[3].d1 = 1'b0;
        drive("tlb_pme", LOOKUP_STORE, WORD, 32'h0002_1ABC, 32'h1234_5ABC, 2'd1, 1'b1, ECODE_PME);
        tlb_entrys[3].v1 = 1'b0;
        drive("tlb_pil", LOOKUP_LOAD,  WORD, 32'h0002_1ABC, 32'h1234_5ABC, 2'd1, 1'b1, ECODE_PIL);
        drive("tlb_pis", LOOKUP_STORE, WORD, 32'h0002_1ABC, 32'h1234_5ABC, 2'd1, 1'b1, ECODE_PIS);
        drive("tlb_pif", LOOKUP_FETCH, WORD, 32'h0002_1AB0, 32'h1234_5AB0, 2'd1, 1'b1, ECODE_PIF);
        drive("tlb_miss", LOOKUP_LOAD, WORD, 32'h0003_0000, 32'h0003_0000, 2'd0, 1'b1, ECODE_TLBR);

        // Misalignment outranks a TLB miss; en only gates the report
        tlb_entrys[3].e = 1'b0;
        tlb_entrys[7].e = 1'b0;
        drive("ale_over_tlbr", LOOKUP_STORE, WORD, 32'h0002_1ABE, 32'h0002_1ABE, 2'd0, 1'b1, ECODE_ALE);
        en = 1'b0;
        drive("ale_en0",       LOOKUP_STORE, WORD, 32'h0002_1ABE, 32'h0002_1ABE, 2'd0, 1'b0, 6'h00);
        en = 1'b1;

        // Huge page with ASID qualification
        tlb_entrys[5] = '{e: 1'b1, vppn: 19'h00400, ps: 6'd21, g: 1'b0, asid: 10'd7,
                          ppn0: 20'h00A00, ppn1: 20'h3FE00, plv0: 2'd3, plv1: 2'd3,
                          mat0: 2'd1, mat1: 2'd0, d0: 1'b0, d1: 1'b0, v0: 1'b1, v1: 1'b1};
        rd_csr.asid.asid = 10'd7;
        drive("huge_even", LOOKUP_LOAD, WORD, 32'h0080_0040, 32'h00A0_0040, 2'd1, 1'b0, 6'h00);
        tlb_entrys[5].ppn0 = 20'h01400;
        drive("huge_even2", LOOKUP_LOAD, WORD, 32'h0080_0040, 32'h0140_0040, 2'd1, 1'b0, 6'h00);
        drive("huge_odd",   LOOKUP_LOAD, WORD, 32'h00A0_0044, 32'h3FE0_0044, 2'd0, 1'b0, 6'h00);
        rd_csr.asid.asid = 10'd8;
        drive("huge_asid", LOOKUP_LOAD, WORD, 32'h0080_0040, 32'h0080_0040, 2'd0, 1'b1, ECODE_TLBR);

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
